cs_window_param: RTL and testbench

CS_WINDOW_PARAM -- requirements
Module: cs_window_param

---
 rtl/cs_window_param.sv | 105 ++++++++++
 tb/tb_cs_window_param.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cs_window_param.sv
// Sliding-window filter: Y = (sum + DEPTH*appr) >> OUT_SHIFT over the last DEPTH samples.
// Define CS_WINDOW_SAT_EN to saturate Y instead of truncating it.
module cs_window_param #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 9,
  parameter int unsigned OUT_SHIFT = 3,
  parameter int unsigned OUT_W     = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] X,
  input  logic              x_valid,
  input  logic              flush,
  output logic [OUT_W-1:0]  Y,
  output logic              y_valid
);

  localparam int unsigned SUM_W  = DATA_W + $clog2(DEPTH) + 1;
  localparam int unsigned FILL_W = $clog2(DEPTH + 1);
  // DEPTH*appr <= sum, so one extra bit covers the final addition
  localparam int unsigned EXT_W  = SUM_W + 1;
  localparam int unsigned WIDE_W = (EXT_W > OUT_W) ? EXT_W : OUT_W + 1;

  logic [DATA_W-1:0] win [DEPTH];
  logic [SUM_W-1:0]  sum;
  logic [FILL_W-1:0] fill;
  logic              pend;

  logic [FILL_W-1:0] fill_inc_c;
  logic [SUM_W-1:0]  avg_c;
  logic [DATA_W-1:0] appr_c;
  logic [WIDE_W-1:0] total_c;
  logic [WIDE_W-1:0] shifted_c;
  logic [OUT_W-1:0]  y_c;

  always_comb begin
    fill_inc_c = (fill == FILL_W'(DEPTH)) ? fill : fill + FILL_W'(1);
  end

  // Largest window sample not exceeding the floor average
  always_comb begin
    avg_c  = sum / SUM_W'(DEPTH);
    appr_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((SUM_W'(win[i]) <= avg_c) && (win[i] > appr_c)) begin
        appr_c = win[i];
      end
    end
  end

  always_comb begin
    total_c   = WIDE_W'(sum) + WIDE_W'(appr_c) * WIDE_W'(DEPTH);
    shifted_c = total_c >> OUT_SHIFT;
`ifdef CS_WINDOW_SAT_EN
    y_c = (|(shifted_c >> OUT_W)) ? '1 : OUT_W'(shifted_c);
`else
    y_c = OUT_W'(shifted_c);
`endif
  end

  // Window/sum update on acceptance; result registered one edge later
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        win[i] <= '0;
      end
      sum     <= '0;
      fill    <= '0;
      pend    <= 1'b0;
      Y       <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= pend & ~flush;
      if (pend && !flush) begin
        Y <= y_c;
      end
      pend <= 1'b0;
      if (x_valid) begin
        if (flush) begin
          for (int unsigned i = 1; i < DEPTH; i++) begin
            win[i] <= '0;
          end
          win[0] <= X;
          sum    <= SUM_W'(X);
          fill   <= FILL_W'(1);
        end else begin
          win[0] <= X;
          for (int unsigned i = 1; i < DEPTH; i++) begin
            win[i] <= win[i-1];
          end
          sum  <= sum + SUM_W'(X) - SUM_W'(win[DEPTH-1]);
          fill <= fill_inc_c;
          pend <= (fill_inc_c == FILL_W'(DEPTH));
        end
      end else if (flush) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          win[i] <= '0;
        end
        sum  <= '0;
        fill <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cs_window_param.sv
// Self-checking bench for cs_window_param against a queue-based window model.
module tb_cs_window_param;

  localparam int D  = 9;
  localparam int SH = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  logic       x_valid = 1'b0;
  logic [7:0] x = '0;
  logic [9:0] y;
  logic       yv;
  logic [8:0] y9;
  logic       yv9;

  int n_chk  = 0;
  int n_fail = 0;

  int q[$];
  bit m_pend = 0;
  int m_pend_y = 0, m_pend_y9 = 0;
  bit m_yv = 0;
  int m_y = 0, m_y9 = 0;

  always #5 clk = ~clk;

  cs_window_param #(.DATA_W(8), .DEPTH(9), .OUT_SHIFT(3), .OUT_W(10)) dut (
    .clk(clk), .reset(reset), .X(x), .x_valid(x_valid), .flush(flush),
    .Y(y), .y_valid(yv));

  cs_window_param #(.DATA_W(8), .DEPTH(9), .OUT_SHIFT(3), .OUT_W(9)) dut9 (
    .clk(clk), .reset(reset), .X(x), .x_valid(x_valid), .flush(flush),
    .Y(y9), .y_valid(yv9));

  function automatic int fit(input int full, input int w);
    int lim;
    lim = (1 << w) - 1;
`ifdef CS_WINDOW_SAT_EN
    return (full > lim) ? lim : full;
`else
    return full & lim;
`endif
  endfunction

  function automatic void result(input int s[$], output int r10, output int r9);
    int sum, avg, appr, full;
    sum = 0;
    foreach (s[i]) sum += s[i];
    avg  = sum / D;
    appr = 0;
    foreach (s[i]) if (s[i] <= avg && s[i] > appr) appr = s[i];
    full = (sum + D * appr) >> SH;
    r10  = fit(full, 10);
    r9   = fit(full, 9);
  endfunction

  // Drive one cycle, advance the model across the edge, settle outputs
  task automatic cyc(input logic r, input logic f, input logic v, input logic [7:0] d);
    reset = r; flush = f; x_valid = v; x = d;
    @(posedge clk);
    if (r) begin
      q.delete(); m_pend = 0; m_yv = 0; m_y = 0; m_y9 = 0;
    end else begin
      m_yv = m_pend && !f;
      if (m_yv) begin m_y = m_pend_y; m_y9 = m_pend_y9; end
      m_pend = 0;
      if (v) begin
        if (f) begin
          q.delete(); q.push_back(int'(d));
        end else begin
          q.push_back(int'(d));
          if (q.size() > D) void'(q.pop_front());
          if (q.size() == D) begin
            m_pend = 1;
            result(q, m_pend_y, m_pend_y9);
          end
        end
      end else if (f) begin
        q.delete();
      end
    end
    #1;
  endtask

  task automatic test_reset;
    cyc(1, 0, 0, 8'h00);
    n_chk++;
    if (y !== 10'h000 || yv !== 1'b0 || y9 !== 9'h000 || yv9 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: Y=%0h y_valid=%0b Y9=%0h y_valid9=%0b required 0 0 0 0", y, yv, y9, yv9);
    end
  endtask

  task automatic test_ramp;
    int nv = 0;
    cyc(1, 0, 0, 8'h00);
    for (int i = 1; i <= 10; i++) begin
      if (i <= 9) cyc(0, 0, 1, 8'(i)); else cyc(0, 0, 0, 8'h00);
      nv += int'(yv);
      n_chk++;
      if (yv !== m_yv || yv9 !== m_yv || y !== 10'(m_y) || y9 !== 9'(m_y9)) begin
        n_fail++;
        $display("FAIL ramp cyc %0d: y_valid=%0b Y=%0h Y9=%0h required %0b %0h %0h", i, yv, y, y9, m_yv, m_y, m_y9);
      end
    end
    n_chk++;
    if (yv !== 1'b1 || y !== 10'h00B || nv != 1) begin
      n_fail++;
      $display("FAIL ramp result: y_valid=%0b Y=%0h count=%0d required 1 00b 1", yv, y, nv);
    end
  endtask

  task automatic test_full;
    logic [8:0] e9;
`ifdef CS_WINDOW_SAT_EN
    e9 = 9'h1FF;
`else
    e9 = 9'h03D;
`endif
    cyc(1, 0, 0, 8'h00);
    for (int i = 1; i <= 11; i++) begin
      if (i <= 10) cyc(0, 0, 1, 8'hFF); else cyc(0, 0, 0, 8'h00);
      n_chk++;
      if (yv !== m_yv || yv9 !== m_yv || y !== 10'(m_y) || y9 !== 9'(m_y9)) begin
        n_fail++;
        $display("FAIL full cyc %0d: y_valid=%0b Y=%0h Y9=%0h required %0b %0h %0h", i, yv, y, y9, m_yv, m_y, m_y9);
      end
      if (i >= 10) begin
        n_chk++;
        if (yv !== 1'b1 || y !== 10'h23D || y9 !== e9) begin
          n_fail++;
          $display("FAIL full result %0d: y_valid=%0b Y=%0h Y9=%0h required 1 23d %0h", i, yv, y, y9, e9);
        end
      end
    end
  endtask

  task automatic test_stall;
    int nv = 0;
    cyc(1, 0, 0, 8'h00);
    for (int i = 1; i <= 13; i++) begin
      if (i <= 4) cyc(0, 0, 1, 8'(i));
      else if (i <= 7) cyc(0, 0, 0, 8'hAA);
      else if (i <= 12) cyc(0, 0, 1, 8'(i - 3));
      else cyc(0, 0, 0, 8'h00);
      nv += int'(yv);
      n_chk++;
      if (yv !== m_yv || y !== 10'(m_y) || y9 !== 9'(m_y9)) begin
        n_fail++;
        $display("FAIL stall cyc %0d: y_valid=%0b Y=%0h required %0b %0h", i, yv, y, m_yv, m_y);
      end
    end
    n_chk++;
    if (yv !== 1'b1 || y !== 10'h00B || nv != 1) begin
      n_fail++;
      $display("FAIL stall result: y_valid=%0b Y=%0h count=%0d required 1 00b 1", yv, y, nv);
    end
  endtask

  task automatic test_flush;
    for (int mode = 0; mode < 2; mode++) begin
      int nv = 0;
      cyc(1, 0, 0, 8'h00);
      for (int i = 0; i < 5; i++) cyc(0, 0, 1, 8'($urandom_range(255)));
      if (mode == 0) begin
        cyc(0, 1, 0, 8'h00);
        cyc(0, 0, 1, 8'h01);
      end else begin
        cyc(0, 1, 1, 8'h01);
      end
      for (int i = 2; i <= 10; i++) begin
        if (i <= 9) cyc(0, 0, 1, 8'(i)); else cyc(0, 0, 0, 8'h00);
        nv += int'(yv);
        n_chk++;
        if (yv !== m_yv || y !== 10'(m_y) || y9 !== 9'(m_y9)) begin
          n_fail++;
          $display("FAIL flush m%0d cyc %0d: y_valid=%0b Y=%0h required %0b %0h", mode, i, yv, y, m_yv, m_y);
        end
      end
      n_chk++;
      if (yv !== 1'b1 || y !== 10'h00B || nv != 1) begin
        n_fail++;
        $display("FAIL flush m%0d result: y_valid=%0b Y=%0h count=%0d required 1 00b 1", mode, yv, y, nv);
      end
    end
  endtask

  task automatic test_reset_mid;
    cyc(1, 0, 0, 8'h00);
    for (int i = 1; i <= 9; i++) cyc(0, 0, 1, 8'h40);
    cyc(0, 0, 0, 8'h00);
    for (int i = 1; i <= 4; i++) cyc(0, 0, 1, 8'(i));
    cyc(1, 0, 1, 8'h77);
    n_chk++;
    if (y !== 10'h000 || yv !== 1'b0) begin
      n_fail++;
      $display("FAIL reset mid-fill: Y=%0h y_valid=%0b required 0 0", y, yv);
    end
    for (int i = 1; i <= 9; i++) cyc(0, 0, 1, 8'(i + 20));
    cyc(1, 0, 0, 8'h00);
    n_chk++;
    if (y !== 10'h000 || yv !== 1'b0) begin
      n_fail++;
      $display("FAIL reset at result: Y=%0h y_valid=%0b required 0 0", y, yv);
    end
    for (int i = 1; i <= 10; i++) begin
      if (i <= 9) cyc(0, 0, 1, 8'(i)); else cyc(0, 0, 0, 8'h00);
      n_chk++;
      if (yv !== m_yv || y !== 10'(m_y) || y9 !== 9'(m_y9)) begin
        n_fail++;
        $display("FAIL reset refill cyc %0d: y_valid=%0b Y=%0h required %0b %0h", i, yv, y, m_yv, m_y);
      end
    end
    n_chk++;
    if (yv !== 1'b1 || y !== 10'h00B) begin
      n_fail++;
      $display("FAIL reset refill result: y_valid=%0b Y=%0h required 1 00b", yv, y);
    end
  endtask

  task automatic test_random;
    cyc(1, 0, 0, 8'h00);
    for (int i = 0; i < 600; i++) begin
      logic r, f, v;
      logic [7:0] d;
      r = ($urandom_range(99) < 2);
      f = ($urandom_range(99) < 4);
      v = ($urandom_range(99) < 80);
      d = (i % 200 < 100) ? 8'($urandom_range(255)) : 8'($urandom_range(15));
      cyc(r, f, v, d);
      n_chk++;
      if (yv !== m_yv || yv9 !== m_yv || y !== 10'(m_y) || y9 !== 9'(m_y9)) begin
        n_fail++;
        $display("FAIL random cyc %0d: y_valid=%0b Y=%0h Y9=%0h required %0b %0h %0h", i, yv, y, y9, m_yv, m_y, m_y9);
      end
    end
  endtask

  initial begin
    test_reset;
    test_ramp;
    test_full;
    test_stall;
    test_flush;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
